// File: rtl/otp_decifra_pkg.sv
// Shared types and default sizes for the one-time-pad decryption controller.
package otp_decifra_pkg;

    localparam int BITS_DEF     = 64;
    localparam int KEY_BITS_DEF = 32;
    localparam int GROUP_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/otp_decifra_ctrl_xor_gate.sv
// Single-bit combinational XOR used as the shared decryption datapath.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = a ^ b;

endmodule

// File: rtl/otp_decifra_ctrl.sv
// Bit-serial one-time-pad decryption controller.
// Walks the captured ciphertext MSB-first through one shared xor_gate, applies
// the pad cyclically and streams plaintext bytes over a valid/ready handshake.
// Optional build macro DECIFRA_PLAIN_OUT_EN adds plain_out_o, the whole
// plaintext word assembled from the accepted bytes.
//
// state | meaning
// IDLE  | waiting for start_i, operands not yet captured
// SHIFT | one ciphertext bit decrypted per cycle into the byte shift register
// EMIT  | byte presented with byte_valid_o, waiting for byte_ready_i
// DONE  | one-cycle done pulse after the last accepted byte
module otp_decifra_ctrl
    import otp_decifra_pkg::*;
#(
    parameter int BITS     = BITS_DEF,
    parameter int KEY_BITS = KEY_BITS_DEF,
    parameter int GROUP    = GROUP_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [BITS-1:0]     cipher_in_i,
    input  logic [KEY_BITS-1:0] otp_in_i,
    output logic                busy_o,
    output logic [GROUP-1:0]    byte_out_o,
    output logic                byte_valid_o,
    input  logic                byte_ready_i,
`ifdef DECIFRA_PLAIN_OUT_EN
    output logic [BITS-1:0]     plain_out_o,
`endif
    output logic                done_o
);

    // idx_q carries one extra MSB: it becomes set once the index steps past 0,
    // which is how EMIT knows the final byte has just been produced.
    localparam int IW = $clog2(BITS);
    localparam int KW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;

    localparam logic [IW:0]   IDX_START = (IW+1)'(BITS - 1);
    localparam logic [IW:0]   IDX_ONE   = (IW+1)'(1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BITS - 1);
    localparam logic [KW-1:0] KEY_ONE   = KW'(1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(GROUP - 1);
    localparam logic [GW-1:0] GRP_ONE   = GW'(1);

    state_e                state_q;
    logic [BITS-1:0]       cipher_q;
    logic [KEY_BITS-1:0]   otp_q;
    logic [IW:0]           idx_q;
    logic [KW-1:0]         kidx_q;
    logic [GW-1:0]         gcnt_q;
    logic [GROUP-1:0]      sreg_q;
    logic                  busy_q;
    logic                  valid_q;
    logic                  done_q;
    logic                  plain_bit;
`ifdef DECIFRA_PLAIN_OUT_EN
    logic [BITS-1:0]       plain_q;
`endif

    // The pad index runs alongside the cipher index; because BITS is a multiple
    // of KEY_BITS, starting it at KEY_BITS-1 and wrapping gives idx mod KEY_BITS.
    xor_gate u_xor (
        .a   (cipher_q[idx_q[IW-1:0]]),
        .b   (otp_q[kidx_q]),
        .out (plain_bit)
    );

    // Sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cipher_q <= '0;
            otp_q    <= '0;
            idx_q    <= '0;
            kidx_q   <= '0;
            gcnt_q   <= '0;
            sreg_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef DECIFRA_PLAIN_OUT_EN
            plain_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        cipher_q <= cipher_in_i;
                        otp_q    <= otp_in_i;
                        idx_q    <= IDX_START;
                        kidx_q   <= KEY_LAST;
                        gcnt_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
`ifdef DECIFRA_PLAIN_OUT_EN
                        plain_q  <= '0;
`endif
                    end
                end
                SHIFT: begin
                    sreg_q <= {sreg_q[GROUP-2:0], plain_bit};
                    idx_q  <= idx_q - IDX_ONE;
                    kidx_q <= (kidx_q == '0) ? KEY_LAST : (kidx_q - KEY_ONE);
                    gcnt_q <= gcnt_q + GRP_ONE;
                    if (gcnt_q == GRP_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (byte_ready_i) begin
                        valid_q <= 1'b0;
`ifdef DECIFRA_PLAIN_OUT_EN
                        plain_q <= {plain_q[BITS-GROUP-1:0], sreg_q};
`endif
                        if (idx_q[IW]) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            gcnt_q  <= '0;
                            state_q <= SHIFT;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign byte_out_o   = sreg_q;
    assign byte_valid_o = valid_q;
    assign done_o       = done_q;
`ifdef DECIFRA_PLAIN_OUT_EN
    assign plain_out_o  = plain_q;
`endif

endmodule

// File: tb/tb_otp_decifra_ctrl.sv
// Directed bench for otp_decifra_ctrl: decrypt, backpressure, start while busy,
// reset mid-operation and an all-zero pad.
module tb_otp_decifra_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] cipher;
    logic [31:0] otp;
    logic        busy;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;
`ifdef DECIFRA_PLAIN_OUT_EN
    logic [63:0] plain_out;
`endif

    int checks   = 0;
    int failures = 0;

    otp_decifra_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .cipher_in_i  (cipher),
        .otp_in_i     (otp),
        .busy_o       (busy),
        .byte_out_o   (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
`ifdef DECIFRA_PLAIN_OUT_EN
        .plain_out_o  (plain_out),
`endif
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one message; cycle 1 is the cycle right after the accepting edge.
    task automatic run_msg(input string tag, input logic [63:0] c, input logic [31:0] k,
                           input logic [63:0] expv, input int stall_byte, input int stall_n,
                           input int exp_done, input bit midstart);
        int         cyc;
        int         nb;
        int         stall_cnt;
        bit         pending;
        bit         got_done;
        logic [7:0] held;
        nb = 0; stall_cnt = 0; pending = 0; got_done = 0; held = '0;
        @(negedge clk);
        start = 1'b1; cipher = c; otp = k; byte_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        while (cyc < 200 && !got_done) begin
            if (midstart && cyc == 4) begin
                start = 1'b1; cipher = ~c; otp = ~k;
            end else if (midstart && cyc == 5) begin
                start = 1'b0;
            end
            if (byte_valid) begin
                if (!pending) begin
                    chk($sformatf("%s_byte%0d", tag, nb), {56'd0, byte_out}, {56'd0, expv[63-8*nb -: 8]});
                    chk($sformatf("%s_byte%0d_cycle", tag, nb), 64'(cyc), 64'((nb + 1) * 9 + stall_cnt));
                    held = byte_out;
                    pending = 1'b1;
                end else begin
                    chk($sformatf("%s_hold%0d", tag, nb), {56'd0, byte_out}, {56'd0, held});
                end
                if (nb == stall_byte && stall_cnt < stall_n) begin
                    byte_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    byte_ready = 1'b1;
                    pending = 1'b0;
                    nb++;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
                chk({tag, "_byte_count"}, 64'(nb), 64'd8);
`ifdef DECIFRA_PLAIN_OUT_EN
                chk({tag, "_plain_out"}, plain_out, expv);
`endif
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got_done) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, {63'd0, done}, 64'd0);
        chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
`ifdef DECIFRA_PLAIN_OUT_EN
        chk({tag, "_plain_stable"}, plain_out, expv);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cipher = '0; otp = '0; byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, byte_valid}, 64'd0);
        chk("rst_byte", {56'd0, byte_out}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // "estrelas", free-flowing
        run_msg("dec", 64'h031A0217_03051716, 32'h66697665, 64'h65737472_656C6173, -1, 0, 73, 1'b0);

        // byte 2 held for three extra cycles
        run_msg("bp", 64'h031A0217_03051716, 32'h66697665, 64'h65737472_656C6173, 2, 3, 76, 1'b0);

        // start pulsed with other operands while shifting
        run_msg("busy_start", 64'h031A0217_03051716, 32'h66697665, 64'h65737472_656C6173, -1, 0, 73, 1'b1);

        // reset while byte 3 is being presented
        @(negedge clk);
        start = 1'b1; cipher = 64'h031A0217_03051716; otp = 32'h66697665; byte_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        chk("rstmid_pre_valid", {63'd0, byte_valid}, 64'd1);
        chk("rstmid_pre_byte", {56'd0, byte_out}, 64'h72);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_valid", {63'd0, byte_valid}, 64'd0);
        chk("rstmid_byte", {56'd0, byte_out}, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
`ifdef DECIFRA_PLAIN_OUT_EN
        chk("rstmid_plain", plain_out, 64'd0);
`endif
        @(posedge clk); #1;
        chk("rstmid_idle_busy", {63'd0, busy}, 64'd0);
        run_msg("after_rst", 64'h031A0217_03051716, 32'h66697665, 64'h65737472_656C6173, -1, 0, 73, 1'b0);

        // zero pad passes the ciphertext straight through
        run_msg("zero_pad", 64'hDEADBEEF_01234567, 32'h0, 64'hDEADBEEF_01234567, -1, 0, 73, 1'b0);

`ifdef DECIFRA_PLAIN_OUT_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("plain_after_rst", plain_out, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
